// File: rtl/subwordreadspill_if.sv
// Load beat/result bundle between the cache read mux and the subword read extractor.
// The master side issues loads and supplies beats; the slave side returns results.
interface subwordreadspill_if #(
   parameter int LLEN = 64,
   parameter int OFFW = $clog2(LLEN / 8)
);
   logic              LoadReqM;
   logic [OFFW-1:0]   PAdrM;
   logic [2:0]        Funct3M;
   logic              FpLoadStoreM;
   logic              BigEndianM;
   logic              FlushM;
   logic              BeatValidM;
   logic [LLEN-1:0]   ReadDataWordM;
   logic              NextBeatReqM;
   logic              BusyM;
   logic              ReadDataValidM;
   logic [LLEN-1:0]   ReadDataM;

   modport master (
      output LoadReqM, PAdrM, Funct3M, FpLoadStoreM, BigEndianM, FlushM,
             BeatValidM, ReadDataWordM,
      input  NextBeatReqM, BusyM, ReadDataValidM, ReadDataM
   );

   modport slave (
      input  LoadReqM, PAdrM, Funct3M, FpLoadStoreM, BigEndianM, FlushM,
             BeatValidM, ReadDataWordM,
      output NextBeatReqM, BusyM, ReadDataValidM, ReadDataM
   );
endinterface

// File: rtl/subwordreadspill.sv
// Sequential subword load extractor. Captures one or two beats per load (two when the
// access crosses the beat boundary), then extracts, byte-swaps and extends/NaN-boxes
// the addressed field. The result is shown during DONE and held in readDataReg after.
module subwordreadspill #(
   parameter int LLEN = 64
) (
   input  logic clk,
   input  logic reset,
   subwordreadspill_if.slave lsu
);
   localparam int NB   = LLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int WINW = $clog2(2 * LLEN);
   localparam int FLDW = $clog2(LLEN);

   typedef enum logic [1:0] {IDLE = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2, DONE = 2'd3} stateT;

   stateT            stateReg, stateNext;
   logic [OFFW-1:0]  offReg;
   logic [2:0]       funct3Reg;
   logic             fpReg;
   logic             beReg;
   logic [LLEN-1:0]  loReg;
   logic [LLEN-1:0]  hiReg;
   logic [LLEN-1:0]  readDataReg;

   logic [4:0]       sizeLat;
   logic [5:0]       endByte;
   logic             spill;
   logic [2*LLEN-1:0] window;
   logic [LLEN-1:0]  fieldVal;
   logic [LLEN-1:0]  extracted;
   logic [FLDW-1:0]  topIdx;
   logic             topBit;
   logic             legal;
   logic             extBit;
   logic             acceptReq;
   logic             acceptLo;
   logic             acceptHi;
   logic             resultValid;

   // Access size in bytes from the latched controls; flq is the only 16-byte case.
   always_comb begin
      if (funct3Reg == 3'b100 && fpReg) sizeLat = 5'd16;
      else                              sizeLat = 5'd1 << funct3Reg[1:0];
   end

   assign endByte   = 6'(offReg) + 6'(sizeLat);
   assign spill     = endByte > 6'(NB);
   assign acceptReq = (stateReg == IDLE)  && lsu.LoadReqM   && !lsu.FlushM;
   assign acceptLo  = (stateReg == BEAT1) && lsu.BeatValidM && !lsu.FlushM;
   assign acceptHi  = (stateReg == BEAT2) && lsu.BeatValidM && !lsu.FlushM;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stateReg <= IDLE;
      else        stateReg <= stateNext;
   end

   // Next-state logic; a flush anywhere past IDLE abandons the load.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:  if (acceptReq) stateNext = BEAT1;
         BEAT1: begin
            if (lsu.FlushM)          stateNext = IDLE;
            else if (lsu.BeatValidM) stateNext = spill ? BEAT2 : DONE;
         end
         BEAT2: begin
            if (lsu.FlushM)          stateNext = IDLE;
            else if (lsu.BeatValidM) stateNext = DONE;
         end
         DONE:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Output decode; a flush during DONE suppresses the strobe in the same cycle.
   always_comb begin
      lsu.BusyM          = (stateReg != IDLE);
      lsu.NextBeatReqM   = acceptLo && spill;
      resultValid        = (stateReg == DONE) && !lsu.FlushM;
      lsu.ReadDataValidM = resultValid;
   end

   assign lsu.ReadDataM = resultValid ? extracted : readDataReg;

   // Latch the load controls when a request is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         offReg    <= '0;
         funct3Reg <= '0;
         fpReg     <= 1'b0;
         beReg     <= 1'b0;
      end else if (acceptReq) begin
         offReg    <= lsu.PAdrM;
         funct3Reg <= lsu.Funct3M;
         fpReg     <= lsu.FpLoadStoreM;
         beReg     <= lsu.BigEndianM;
      end
   end

   // Beat capture; Hi is cleared with the first beat so a non-spill load sees zeros.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         loReg <= '0;
         hiReg <= '0;
      end else if (acceptLo) begin
         loReg <= lsu.ReadDataWordM;
         hiReg <= '0;
      end else if (acceptHi) begin
         hiReg <= lsu.ReadDataWordM;
      end
   end

   // Hold the result once it has been strobed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           readDataReg <= '0;
      else if (resultValid) readDataReg <= extracted;
   end

   assign window = {hiReg, loReg} >> {offReg, 3'b000};

   // Field extraction, with optional byte reversal within the access size.
   always_comb begin
      logic [WINW-1:0] srcIdx;
      fieldVal = '0;
      srcIdx   = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < int'(sizeLat)) begin
            if (beReg) srcIdx = WINW'(8 * ((int'(sizeLat) - 1 - i) & (2 * NB - 1)));
            else       srcIdx = WINW'(8 * i);
            fieldVal[8*i +: 8] = window[srcIdx +: 8];
         end
      end
   end

   assign topIdx = FLDW'(8 * int'(sizeLat) - 1);
   assign topBit = fieldVal[topIdx];

   // Sign/zero extension or NaN-boxing; unsupported encodings pass Lo through.
   always_comb begin
      legal  = (int'(sizeLat) <= NB);
      extBit = 1'b0;
      case (funct3Reg)
         3'b000:                 extBit = topBit;
         3'b001, 3'b010, 3'b011: extBit = topBit | fpReg;
         3'b111:                 legal  = 1'b0;
         default:                extBit = 1'b0;
      endcase
      extracted = loReg;
      if (legal) begin
         for (int i = 0; i < NB; i++) begin
            if (i < int'(sizeLat)) extracted[8*i +: 8] = fieldVal[8*i +: 8];
            else                   extracted[8*i +: 8] = {8{extBit}};
         end
      end
   end
endmodule
